// File: rtl/coco_bus_arbiter.sv
// Two-master bus arbiter with per-transaction timeout in front of the system bridge.
// Optional macro ARB_ROUND_ROBIN_EN selects round-robin tie-breaking; default is fixed priority to master 0.
module coco_bus_arbiter #(
    parameter int TIMEOUT = 16
) (
    input  logic        Clk,
    input  logic        Reset,

    input  logic [29:0] M0A,
    input  logic [3:0]  M0BE,
    input  logic [31:0] M0WData,
    input  logic        M0Req,
    input  logic        M0RW,
    output logic [31:0] M0RData,
    output logic        M0Ready,

    input  logic [29:0] M1A,
    input  logic [3:0]  M1BE,
    input  logic [31:0] M1WData,
    input  logic        M1Req,
    input  logic        M1RW,
    output logic [31:0] M1RData,
    output logic        M1Ready,

    output logic [29:0] PrA,
    output logic [3:0]  PrBE,
    output logic [31:0] PrWData,
    output logic        PrReq,
    output logic        PrRW,
    input  logic [31:0] PrRData,
    input  logic        PrReady,

    output logic [1:0]  Gnt,
    output logic        BusErr
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } state_t;

    localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

    state_t     state_q, state_d;
    logic [7:0] cnt_q, cnt_d;

    logic own0, own1, own;
    logic req_g;
    logic tmo;
    logic tie_win1;

    assign own0  = (state_q == OWN0);
    assign own1  = (state_q == OWN1);
    assign own   = own0 | own1;
    assign req_g = (own0 & M0Req) | (own1 & M1Req);

    // A timeout only fires while the owner still requests and the bridge is silent.
    assign tmo   = own & req_g & ~PrReady & (cnt_q == TMO_LAST);

`ifdef ARB_ROUND_ROBIN_EN
    logic last_q, last_d;

    assign tie_win1 = ~last_q;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            last_q <= 1'b1;
        end else begin
            last_q <= last_d;
        end
    end
`else
    assign tie_win1 = 1'b0;
`endif

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q <= IDLE;
            cnt_q   <= 8'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
`ifdef ARB_ROUND_ROBIN_EN
        last_d  = last_q;
`endif
        case (state_q)
            IDLE: begin
                cnt_d = 8'd0;
                if (M0Req && M1Req) begin
                    state_d = tie_win1 ? OWN1 : OWN0;
                end else if (M0Req) begin
                    state_d = OWN0;
                end else if (M1Req) begin
                    state_d = OWN1;
                end
            end
            OWN0, OWN1: begin
                if (!req_g) begin
                    state_d = IDLE;
                end else if (PrReady) begin
                    state_d = IDLE;
`ifdef ARB_ROUND_ROBIN_EN
                    last_d  = own1;
`endif
                end else if (tmo) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = 8'd0;
            end
        endcase
    end

    // Bridge side is fully gated: only the owner's signals are forwarded.
    always_comb begin
        PrA     = '0;
        PrBE    = '0;
        PrWData = '0;
        PrReq   = 1'b0;
        PrRW    = 1'b0;
        if (own0) begin
            PrA     = M0A;
            PrBE    = M0BE;
            PrWData = M0WData;
            PrReq   = M0Req;
            PrRW    = M0RW;
        end else if (own1) begin
            PrA     = M1A;
            PrBE    = M1BE;
            PrWData = M1WData;
            PrReq   = M1Req;
            PrRW    = M1RW;
        end
    end

    // A dropped request suppresses Ready; a timeout forces Ready with zero data.
    always_comb begin
        M0Ready = 1'b0;
        M1Ready = 1'b0;
        M0RData = '0;
        M1RData = '0;
        if (own0) begin
            M0Ready = req_g & (PrReady | tmo);
            M0RData = tmo ? 32'h0000_0000 : PrRData;
        end else if (own1) begin
            M1Ready = req_g & (PrReady | tmo);
            M1RData = tmo ? 32'h0000_0000 : PrRData;
        end
    end

    assign Gnt    = {own1, own0};
    assign BusErr = tmo;

endmodule

// File: tb/tb_coco_bus_arbiter.sv
// Directed self-checking bench for coco_bus_arbiter (TIMEOUT = 4) with a completion scoreboard.
module tb_coco_bus_arbiter;

    logic        Clk, Reset;
    logic [29:0] M0A, M1A, PrA;
    logic [3:0]  M0BE, M1BE, PrBE;
    logic [31:0] M0WData, M1WData, PrWData;
    logic        M0Req, M1Req, M0RW, M1RW;
    logic [31:0] M0RData, M1RData, PrRData;
    logic        M0Ready, M1Ready;
    logic        PrReq, PrRW, PrReady;
    logic [1:0]  Gnt;
    logic        BusErr;

    coco_bus_arbiter #(.TIMEOUT(4)) dut (
        .Clk(Clk), .Reset(Reset),
        .M0A(M0A), .M0BE(M0BE), .M0WData(M0WData), .M0Req(M0Req), .M0RW(M0RW),
        .M0RData(M0RData), .M0Ready(M0Ready),
        .M1A(M1A), .M1BE(M1BE), .M1WData(M1WData), .M1Req(M1Req), .M1RW(M1RW),
        .M1RData(M1RData), .M1Ready(M1Ready),
        .PrA(PrA), .PrBE(PrBE), .PrWData(PrWData), .PrReq(PrReq), .PrRW(PrRW),
        .PrRData(PrRData), .PrReady(PrReady),
        .Gnt(Gnt), .BusErr(BusErr)
    );

    typedef struct {
        int          m;
        logic [31:0] rd;
        logic        be;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;
    int   mlast;
    int   w;

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge Clk);
        #1;
    endtask

    task automatic expect_done(input string tag);
        exp_t e;
        if (sb.size() == 0) begin
            checks++;
            failures++;
            $error("FAIL %s observed=completion expected=empty_scoreboard", tag);
        end else begin
            e = sb.pop_front();
            chk({tag, "_rdy"}, {M1Ready, M0Ready}, (e.m == 1) ? 2'b10 : 2'b01);
            chk({tag, "_rdata"}, (e.m == 1) ? M1RData : M0RData, e.rd);
            chk({tag, "_other_rdata"}, (e.m == 1) ? M0RData : M1RData, 32'h0);
            chk({tag, "_buserr"}, BusErr, e.be);
        end
    endtask

    function automatic int tie_winner(input int last);
`ifdef ARB_ROUND_ROBIN_EN
        return (last == 0) ? 1 : 0;
`else
        return (last < 0) ? 1 : 0;
`endif
    endfunction

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        failures++;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    initial begin
        Reset = 1'b1;
        M0A = '0; M0BE = '0; M0WData = '0; M0Req = 1'b0; M0RW = 1'b0;
        M1A = '0; M1BE = '0; M1WData = '0; M1Req = 1'b0; M1RW = 1'b0;
        PrRData = '0; PrReady = 1'b0;
        repeat (2) @(posedge Clk);
        #3;
        chk("rst_pr", {PrA, PrBE, PrWData, PrReq, PrRW}, '0);
        chk("rst_ctl", {Gnt, BusErr, M0Ready, M1Ready}, '0);
        chk("rst_rdata", {M0RData, M1RData}, '0);
        cyc();
        Reset = 1'b0;
        mlast = 1;

        // Tied requests held continuously, zero-wait bridge.
        for (int k = 0; k < 4; k++) begin
            cyc();
            if (k == 0) begin
                M0A = 30'h0000_0100; M1A = 30'h0000_0200;
                M0Req = 1'b1; M1Req = 1'b1;
                PrReady = 1'b1; PrRData = 32'h5555_AAAA;
            end
            #2;
            chk("tie_idle_gnt", Gnt, 2'b00);
            w = tie_winner(mlast);
            sb.push_back('{w, 32'h5555_AAAA, 1'b0});
            cyc();
            #2;
            chk("tie_gnt", Gnt, (w == 1) ? 2'b10 : 2'b01);
            chk("tie_pra", PrA, (w == 1) ? 30'h0000_0200 : 30'h0000_0100);
            expect_done("tie");
            mlast = w;
        end
        cyc();
        M0Req = 1'b0; M1Req = 1'b0;
        #2;
        chk("tie_end", {Gnt, PrReq}, '0);

        // Single read from master 0.
        cyc();
        M0A = 30'h0000_0C00; M0RW = 1'b0; M0BE = 4'hF; M0Req = 1'b1;
        PrReady = 1'b1; PrRData = 32'h1234_5678;
        sb.push_back('{0, 32'h1234_5678, 1'b0});
        #2;
        chk("rd_idle", {Gnt, PrReq}, '0);
        cyc();
        #2;
        chk("rd_gnt", Gnt, 2'b01);
        chk("rd_pra", {PrA, PrReq, PrRW}, {30'h0000_0C00, 1'b1, 1'b0});
        expect_done("rd");
        mlast = 0;
        cyc();
        M0Req = 1'b0;
        #2;
        chk("rd_after", {Gnt, PrReq, M0Ready}, '0);

        // Write from master 1 while master 0 is idle but drives other values.
        cyc();
        M1A = 30'h0000_1234; M1BE = 4'b0011; M1WData = 32'hCAFE_F00D; M1RW = 1'b1; M1Req = 1'b1;
        M0A = 30'h3FFF_FFFF; M0BE = 4'hC; M0WData = 32'h1111_2222; M0RW = 1'b0;
        PrRData = 32'h0BAD_0BAD; PrReady = 1'b1;
        sb.push_back('{1, 32'h0BAD_0BAD, 1'b0});
        #2;
        chk("wr_idle_gated", {PrA, PrBE, PrWData, PrRW, PrReq}, '0);
        cyc();
        #2;
        chk("wr_gnt", Gnt, 2'b10);
        chk("wr_be", PrBE, 4'b0011);
        chk("wr_wdata", PrWData, 32'hCAFE_F00D);
        chk("wr_rw_addr", {PrRW, PrA}, {1'b1, 30'h0000_1234});
        chk("wr_m0_quiet", {M0Ready, M0RData}, '0);
        expect_done("wr");
        mlast = 1;
        cyc();
        M1Req = 1'b0; M1RW = 1'b0;
        #2;
        chk("wr_after", Gnt, 2'b00);

        // Timeout with a silent bridge.
        cyc();
        M0A = 30'h0000_0C00; M0Req = 1'b1; PrReady = 1'b0; PrRData = 32'hDEAD_BEEF;
        sb.push_back('{0, 32'h0000_0000, 1'b1});
        #2;
        for (int c = 1; c <= 4; c++) begin
            cyc();
            #2;
            chk("to_gnt", Gnt, 2'b01);
            if (c < 4) chk("to_wait", {M0Ready, BusErr}, '0);
            else expect_done("to");
        end
        cyc();
        M0Req = 1'b0;
        #2;
        chk("to_after", {Gnt, BusErr, M0Ready}, '0);

        // PrReady arriving on the timeout cycle wins.
        cyc();
        M0Req = 1'b1;
        sb.push_back('{0, 32'hABCD_0123, 1'b0});
        #2;
        for (int c = 1; c <= 4; c++) begin
            cyc();
            if (c == 4) begin
                PrReady = 1'b1; PrRData = 32'hABCD_0123;
            end
            #2;
            chk("tr_gnt", Gnt, 2'b01);
            if (c < 4) chk("tr_wait", {M0Ready, BusErr}, '0);
            else expect_done("tr");
        end
        cyc();
        M0Req = 1'b0; PrReady = 1'b0;
        #2;
        chk("tr_after", {Gnt, BusErr, M0Ready}, '0);

        // Master 0 drops Req in its second owned cycle.
        cyc();
        M0Req = 1'b1;
        #2;
        cyc();
        #2;
        chk("ed_gnt", Gnt, 2'b01);
        cyc();
        M0Req = 1'b0;
        #2;
        chk("ed_drop", {M0Ready, BusErr}, '0);
        cyc();
        #2;
        chk("ed_idle", {Gnt, M0Ready, BusErr}, '0);

        // Reset while master 1 waits in its second owned cycle.
        cyc();
        M1Req = 1'b1; M1A = 30'h0000_0777; M1BE = 4'hF; M1WData = 32'h7777_7777;
        PrReady = 1'b0; PrRData = 32'hFFFF_FFFF;
        #2;
        cyc();
        #2;
        chk("rs_w1", Gnt, 2'b10);
        cyc();
        #2;
        chk("rs_w2", Gnt, 2'b10);
        #1 Reset = 1'b1;
        #1;
        chk("rs_ctl", {Gnt, PrReq, PrRW, BusErr, M0Ready, M1Ready}, '0);
        chk("rs_pr", {PrA, PrBE, PrWData}, '0);
        chk("rs_rdata", {M0RData, M1RData}, '0);
        cyc();
        cyc();
        Reset = 1'b0;
        mlast = 1;
        M0Req = 1'b1; M0A = 30'h0000_0C00; PrReady = 1'b1; PrRData = 32'h0000_BEEF;
        sb.push_back('{0, 32'h0000_BEEF, 1'b0});
        #2;
        chk("rs_idle", Gnt, 2'b00);
        cyc();
        #2;
        chk("rs_first_gnt", Gnt, 2'b01);
        expect_done("rs");
        cyc();
        M0Req = 1'b0; M1Req = 1'b0;
        #2;
        chk("rs_after", Gnt, 2'b00);

        chk("sb_empty", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/coco_bus_arbiter.md
# coco_bus_arbiter

Two-master arbiter placed between the processor/peripheral bus masters and the system bridge. It lets the MIPS core (master 0) and a DMA-style engine (master 1) share the single processor-side bus (address, byte enables, write data, request, read/write, ready). One transaction is forwarded at a time. A per-transaction timeout guards against a slave that never returns ready.

## Interface
Parameters:
- TIMEOUT, default 16: cycles a granted transaction may wait for PrReady before it is aborted. Legal range 2–255.

Ports:
- Clk  in  1  system clock; all state updates on rising edge.
- Reset  in  1  asynchronous, active-high reset.
- M0A  in  30  master 0 word address [31:2].
- M0BE  in  4  master 0 byte enables.
- M0WData  in  32  master 0 write data.
- M0Req  in  1  master 0 request.
- M0RW  in  1  master 0 direction, 1 = write.
- M0RData  out  32  master 0 read data.
- M0Ready  out  1  master 0 completion pulse.
- M1A, M1BE, M1WData, M1Req, M1RW, M1RData, M1Ready: same widths and meanings for master 1.
- PrA  out  30  bridge address.
- PrBE  out  4  bridge byte enables.
- PrWData  out  32  bridge write data.
- PrReq  out  1  bridge request.
- PrRW  out  1  bridge direction.
- PrRData  in  32  bridge read data.
- PrReady  in  1  bridge completion.
- Gnt  out  2  one-hot current grant; 00 = idle.
- BusErr  out  1  one-cycle pulse on timeout abort.

## Operation
- FSM states: IDLE, OWN0, OWN1.
- IDLE:
  - No Req: stay in IDLE.
  - Exactly one Req: go to that master's OWN state.
  - Both Req: winner is chosen per Configuration.
- OWNx:
  - Pr* outputs = master x signals, combinationally.
  - PrRData is routed to MxRData.
  - MxReady = PrReady.
  - The non-granted master sees Ready = 0 and RData = 0.
- Completion: PrReady = 1 while in OWNx → return to IDLE and record last = x.
- Protocol violation: if the granted MxReq drops before PrReady, return to IDLE with no Ready and no BusErr.
- Timeout:
  - An 8-bit wait counter clears on entering OWNx and increments each OWNx cycle without PrReady.
  - When it reaches TIMEOUT−1 without PrReady: MxReady = 1, MxRData = 32'h0000_0000, BusErr = 1 for that cycle, then go to IDLE.
  - PrReady on the same cycle as the timeout wins: normal completion, no BusErr.
- In IDLE, all Pr* outputs, Gnt, M*Ready and M*RData are 0.
- Pr* outputs are fully gated: a non-granted master's signals never reach the bridge.

## Timing
- Reset state: IDLE, last = 1, counter = 0.
- Outputs during reset: PrA, PrBE, PrWData, PrReq, PrRW = 0; M0/M1 Ready and RData = 0; Gnt = 00; BusErr = 0.
- Arbitration latency: Req first sampled high at edge n → Gnt and PrReq high after edge n (cycle n+1).
- Fastest transaction: a zero-wait bridge (PrReady in the first OWN cycle) gives MxReady in cycle n+1.
- Back-to-back: every transaction is followed by exactly one IDLE cycle. Sustained throughput is one transaction per 2 cycles.
- A master holds Req, A, BE, WData and RW stable until it sees Ready. It may reassert Req in the cycle after Ready.
- Reset asserted mid-transaction: immediate return to IDLE with all outputs 0. No Ready and no BusErr are generated.

## Configuration
- ARB_ROUND_ROBIN_EN defined: on simultaneous requests in IDLE, the master ≠ last wins. Worst-case wait for either master is one transaction plus its IDLE cycle.
- ARB_ROUND_ROBIN_EN undefined: fixed priority, master 0 always wins ties. Master 1 can starve. The last register is not implemented.

## Test plan
- Single read: M0Req with M0A = 30'h0000_0C00, M0RW = 0; bridge returns PrReady in the first cycle with PrRData = 32'h1234_5678 → Gnt = 01 and M0Ready/M0RData = 32'h1234_5678 one cycle after the request, then IDLE.
- Simultaneous requests held continuously, zero-wait bridge, with ARB_ROUND_ROBIN_EN: grants alternate 01, 10, 01, 10. Without the macro: 01, 01, 01…, and M1Ready never pulses.
- Write isolation: M1 write with BE = 4'b0011 and WData = 32'hCAFE_F00D while M0 is idle → PrBE = 0011, PrWData = CAFE_F00D, PrRW = 1; M0Ready stays 0.
- Timeout, TIMEOUT = 4: PrReady held low → exactly at the 4th OWN cycle, M0Ready = 1, M0RData = 0, BusErr = 1 for one cycle, then IDLE. A repeat with PrReady arriving in the 4th cycle → normal completion and BusErr = 0.
- Reset in OWN1 at its second wait cycle → all outputs 0 immediately. After release, with simultaneous requests, master 0 is granted first.
- Early Req drop: M0 deasserts Req in its 2nd OWN cycle → IDLE next cycle, no M0Ready, no BusErr.
